matmult_seq: RTL and testbench

Job sequencer that feeds the 8x8 byte-matrix multiplier core. Accepts a job (base word addresses of A and B in shared row memory) and fetches the 8 rows of A and 8 rows of B over a single 64-bit read port. It loads them into the core via valid/addra/inpa/addrb/inpb, pulses start, waits for done, then holds the 256-bit result until the consumer takes it. It sits between the host/DMA side and the multiplier core.

---
 rtl/matmult_seq.sv | 165 ++++++++++++++++
 tb/tb_matmult_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmult_seq.sv
// rtl/matmult_seq.sv - job sequencer feeding the 8x8 byte-matrix multiplier core (optional watchdog: MMSEQ_TIMEOUT_EN)
module matmult_seq #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_a_base,
    input  logic [ADDR_W-1:0] job_b_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    output logic              mm_valid,
    output logic [2:0]        mm_addra,
    output logic [63:0]       mm_inpa,
    output logic [2:0]        mm_addrb,
    output logic [63:0]       mm_inpb,
    output logic              mm_start,
    input  logic [255:0]      mm_c,
    input  logic              mm_done,
    output logic              res_valid,
    output logic [255:0]      res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_REQ_A     = 4'd1;
    localparam logic [3:0] S_WAIT_A    = 4'd2;
    localparam logic [3:0] S_REQ_B     = 4'd3;
    localparam logic [3:0] S_WAIT_B    = 4'd4;
    localparam logic [3:0] S_PUSH      = 4'd5;
    localparam logic [3:0] S_START     = 4'd6;
    localparam logic [3:0] S_WAIT_DONE = 4'd7;
    localparam logic [3:0] S_OUT       = 4'd8;

    logic [3:0]        state;
    logic [2:0]        row;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [63:0]       a_row;
    logic [ADDR_W-1:0] row_ext;

`ifdef MMSEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    assign err = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

    assign row_ext = {{(ADDR_W-3){1'b0}}, row};

    // Status, request and strobe outputs are pure decodes of the state;
    // the address wraps naturally in ADDR_W-bit arithmetic.
    always_comb begin
        job_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        mem_req   = (state == S_REQ_A) || (state == S_REQ_B);
        mem_addr  = (state == S_REQ_B) ? (b_base + row_ext) : (a_base + row_ext);
        mm_valid  = (state == S_PUSH);
        mm_start  = (state == S_START);
    end

    // Sequencer: fetch A/B row pairs, push each pair to the core, start, collect result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            row       <= 3'd0;
            a_base    <= '0;
            b_base    <= '0;
            a_row     <= 64'd0;
            mm_addra  <= 3'd0;
            mm_addrb  <= 3'd0;
            mm_inpa   <= 64'd0;
            mm_inpb   <= 64'd0;
            res_valid <= 1'b0;
            res_data  <= 256'd0;
`ifdef MMSEQ_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        a_base <= job_a_base;
                        b_base <= job_b_base;
                        row    <= 3'd0;
                        state  <= S_REQ_A;
                    end
                end
                S_REQ_A: begin
                    if (mem_gnt) state <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    if (mem_rvalid) begin
                        a_row <= mem_rdata;
                        state <= S_REQ_B;
                    end
                end
                S_REQ_B: begin
                    if (mem_gnt) state <= S_WAIT_B;
                end
                S_WAIT_B: begin
                    // Core-facing row registers only change here, so they hold between pushes.
                    if (mem_rvalid) begin
                        mm_addra <= row;
                        mm_addrb <= row;
                        mm_inpa  <= a_row;
                        mm_inpb  <= mem_rdata;
                        state    <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (row == 3'd7) begin
                        row   <= 3'd0;
                        state <= S_START;
                    end else begin
                        row   <= row + 3'd1;
                        state <= S_REQ_A;
                    end
                end
                S_START: begin
`ifdef MMSEQ_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state  <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (mm_done) begin
                        res_data  <= mm_c;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end
`ifdef MMSEQ_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q     <= 1'b1;
                        res_data  <= 256'd0;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmult_seq.sv
// tb/tb_matmult_seq.sv - scoreboard testbench for matmult_seq
module tb_matmult_seq;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [ADDR_W-1:0] job_a_base = '0;
    logic [ADDR_W-1:0] job_b_base = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [63:0]       mem_rdata = 64'd0;
    logic              mm_valid;
    logic [2:0]        mm_addra;
    logic [63:0]       mm_inpa;
    logic [2:0]        mm_addrb;
    logic [63:0]       mm_inpb;
    logic              mm_start;
    logic [255:0]      mm_c = 256'd0;
    logic              mm_done = 1'b0;
    logic              res_valid;
    logic [255:0]      res_data;
    logic              res_ready = 1'b0;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  row;
        logic [63:0] a;
        logic [63:0] b;
    } load_t;

    logic [ADDR_W-1:0] addr_q[$];
    load_t             load_q[$];
    logic [255:0]      res_q[$];

    always #5 clk = ~clk;

    matmult_seq #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_a_base(job_a_base), .job_b_base(job_b_base),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mm_valid(mm_valid), .mm_addra(mm_addra), .mm_inpa(mm_inpa),
        .mm_addrb(mm_addrb), .mm_inpb(mm_inpb), .mm_start(mm_start),
        .mm_c(mm_c), .mm_done(mm_done),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .err(err)
    );

    function automatic logic [63:0] mdata(input logic [15:0] ad);
        return {ad, ~ad, ad + 16'h1111, ad ^ 16'h5A5A};
    endfunction

    // Runs one job with a reactive memory/core model; every value checked comes from the queues.
    task automatic run_job(input logic [15:0] ab, input logic [15:0] bb,
                           input int gdly, input int rdly, input int hold,
                           input int start_cyc, input int abort_grant,
                           input bit spur, input bit no_done,
                           input logic [255:0] mmc);
        int cyc = 0, grants = 0, wait_cnt = 0, rv_cnt = 0, done_cnt = -1;
        int hold_cnt = 0, loads = 0, start_seen = -1;
        logic [15:0] pend = '0, held = '0;
        logic [2:0]  last_row = '0;
        bit waiting = 0, done_sent = 0, hs = 0, finished = 0;
        load_t ld;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ta, tb;
            ta = ab + 16'(i);
            tb = bb + 16'(i);
            addr_q.push_back(ta);
            addr_q.push_back(tb);
            load_q.push_back('{3'(i), mdata(ta), mdata(tb)});
        end
        res_q.push_back(no_done ? 256'd0 : mmc);
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1) begin
            errors++; $display("FAIL job_ready_idle: got %b want 1", job_ready);
        end
        job_valid = 1'b1; job_a_base = ab; job_b_base = bb;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                job_valid = 1'b0; job_a_base = 16'h0BAD; job_b_base = 16'h0BAD;
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mm_done = 1'b0;
            if (hs) begin
                checks++;
                if (res_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL handshake_release: res_valid=%b job_ready=%b busy=%b want 0 1 0", res_valid, job_ready, busy);
                end
                res_ready = 1'b0;
                void'(res_q.pop_front());
                finished = 1;
                break;
            end
            if (abort_grant >= 0 && grants == abort_grant + 1 && rv_cnt > 0) begin
                rst = 1'b0;
                #1;
                checks++;
                if (job_ready !== 1'b1 || {busy, mem_req, mem_addr, mm_valid, mm_start, res_valid, err} !== '0 ||
                    {mm_addra, mm_addrb, mm_inpa, mm_inpb} !== '0 || res_data !== 256'd0) begin
                    errors++;
                    $display("FAIL abort_reset_outputs: job_ready=%b busy=%b mem_req=%b mem_addr=%h mm_addra=%0d res_valid=%b want reset values",
                             job_ready, busy, mem_req, mem_addr, mm_addra, res_valid);
                end
                addr_q.delete(); load_q.delete(); res_q.delete();
                return;
            end
            checks++;
            if (job_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL busy_status cyc %0d: job_ready=%b busy=%b want 0 1", cyc, job_ready, busy);
            end
            // memory model
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = mdata(pend);
                end
            end else if (mem_req) begin
                if (waiting) begin
                    checks++;
                    if (mem_addr !== held) begin
                        errors++; $display("FAIL addr_stable: got %h want %h", mem_addr, held);
                    end
                end
                held = mem_addr; waiting = 1;
                if (wait_cnt == gdly) begin
                    mem_gnt = 1'b1;
                    checks++;
                    if (addr_q.size() == 0) begin
                        errors++; $display("FAIL mem_addr_extra: got %h want none", mem_addr);
                    end else if (mem_addr !== addr_q[0]) begin
                        errors++; $display("FAIL mem_addr grant %0d: got %h want %h", grants, mem_addr, addr_q[0]);
                    end
                    if (addr_q.size() > 0) void'(addr_q.pop_front());
                    pend = mem_addr; rv_cnt = rdly; wait_cnt = 0; waiting = 0; grants++;
                end else begin
                    wait_cnt++;
                end
                if (spur && (grants % 2 == 1) && !mem_gnt) begin
                    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end
            if (mm_valid) begin
                checks++;
                if (mm_start === 1'b1 || load_q.size() == 0) begin
                    errors++; $display("FAIL mm_valid_unexpected: start=%b pending=%0d want start 0 and pending>0", mm_start, load_q.size());
                end else begin
                    ld = load_q.pop_front();
                    if (mm_addra !== ld.row || mm_addrb !== ld.row || mm_inpa !== ld.a || mm_inpb !== ld.b) begin
                        errors++;
                        $display("FAIL mm_load row %0d: addra=%0d addrb=%0d inpa=%h inpb=%h want %0d %h %h",
                                 ld.row, mm_addra, mm_addrb, mm_inpa, mm_inpb, ld.row, ld.a, ld.b);
                    end
                    last_row = ld.row;
                end
                loads++;
                if (spur) begin
                    mm_done = 1'b1; mm_c = {8{32'hBAD0_BAD0}};
                end
            end else if (loads > 0) begin
                checks++;
                if (mm_addra !== last_row) begin
                    errors++; $display("FAIL mm_addra_hold: got %0d want %0d", mm_addra, last_row);
                end
            end
            if (mm_start) begin
                checks++;
                if (loads != 8 || (start_cyc >= 0 && cyc != start_cyc)) begin
                    errors++; $display("FAIL mm_start: cycle %0d loads %0d want cycle %0d loads 8", cyc, loads, start_cyc);
                end
                start_seen = cyc;
                if (!no_done) done_cnt = 3;
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    mm_done = 1'b1; mm_c = mmc; done_sent = 1; done_cnt = -1;
                end
            end
            if (res_valid) begin
                checks++;
                if (res_data !== res_q[0] || (!no_done && !done_sent)) begin
                    errors++; $display("FAIL res_data: got %h want %h (done_sent=%0d)", res_data, res_q[0], done_sent);
                end
                if (hold_cnt == 0 && no_done) begin
                    checks++;
                    if (cyc - start_seen != 17) begin
                        errors++; $display("FAIL timeout_latency: got %0d want 17", cyc - start_seen);
                    end
                end
                if (hold_cnt == hold) begin
                    res_ready = 1'b1; hs = 1;
                end else begin
                    hold_cnt++;
                end
            end
            if (cyc > 3000) begin
                errors++; checks++;
                $display("FAIL job_timeout: no completion after %0d cycles", cyc);
                finished = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || {busy, mem_req, mem_addr, mm_valid, mm_start, res_valid, err} !== '0 ||
            {mm_addra, mm_addrb, mm_inpa, mm_inpb} !== '0 || res_data !== 256'd0) begin
            errors++;
            $display("FAIL reset_outputs: job_ready=%b busy=%b mem_req=%b mem_addr=%h res_valid=%b want 1 0 0 0000 0",
                     job_ready, busy, mem_req, mem_addr, res_valid);
        end
        rst = 1'b1;
    endtask

    task automatic test_nominal();
        run_job(16'h0100, 16'h0200, 0, 1, 0, 41, -1, 0, 0, {32{8'hA5}});
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL nominal_err: got %b want 0", err);
        end
    endtask

    task automatic test_backpressure();
        run_job(16'h1000, 16'h2000, 3, 2, 10, -1, -1, 0, 0, {8{32'h1234_5678}});
    endtask

    task automatic test_wrap_spurious();
        run_job(16'hFFFC, 16'hFFFE, 1, 1, 2, -1, -1, 1, 0, {16{16'hC0DE}});
    endtask

    task automatic test_reset_midjob();
        run_job(16'h0300, 16'h0400, 0, 1, 0, -1, 9, 0, 0, 256'd1);
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        mm_done = 1'b1; mm_c = {8{32'hFEED_FACE}};
        @(negedge clk);
        mem_rvalid = 1'b0; mm_done = 1'b0;
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 256'd0) begin
            errors++;
            $display("FAIL late_inputs_ignored: job_ready=%b busy=%b res_valid=%b want 1 0 0", job_ready, busy, res_valid);
        end
        run_job(16'h0500, 16'h0600, 0, 1, 1, 41, -1, 0, 0, {4{64'h0123_4567_89AB_CDEF}});
    endtask

    task automatic test_back_to_back();
        run_job(16'h7FFA, 16'h8000, 0, 1, 0, 41, -1, 0, 0, {32{8'h3C}});
        run_job(16'h0010, 16'h0020, 2, 1, 0, -1, -1, 0, 0, {32{8'hC3}});
    endtask

`ifdef MMSEQ_TIMEOUT_EN
    task automatic test_timeout();
        run_job(16'h0A00, 16'h0B00, 0, 1, 0, 41, -1, 0, 1, 256'd0);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL timeout_err: got %b want 1", err);
        end
        run_job(16'h0C00, 16'h0D00, 0, 1, 0, 41, -1, 0, 0, {32{8'h5A}});
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL timeout_err_sticky: got %b want 1", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_wrap_spurious();
        test_reset_midjob();
        test_back_to_back();
`ifdef MMSEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
